// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: flag bit positions,
// flag-update opcodes, branch condition codes and the condition evaluator.
package alu_writeback_pkg;

  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    FOP_HOLD = 2'b00,
    FOP_LOAD = 2'b01,
    FOP_SETC = 2'b10,
    FOP_CLRC = 2'b11
  } flag_op_e;

  typedef enum logic [2:0] {
    BR_AL = 3'b000,
    BR_EQ = 3'b001,
    BR_NE = 3'b010,
    BR_CS = 3'b011,
    BR_CC = 3'b100,
    BR_MI = 3'b101,
    BR_PL = 3'b110,
    BR_NV = 3'b111
  } br_cond_e;

  // Evaluate a branch condition against a {C,N,Z} flag vector.
  function automatic logic br_eval(input br_cond_e cond, input logic [2:0] f);
    logic taken;
    unique case (cond)
      BR_AL: taken = 1'b1;
      BR_EQ: taken = f[FLAG_Z];
      BR_NE: taken = !f[FLAG_Z];
      BR_CS: taken = f[FLAG_C];
      BR_CC: taken = !f[FLAG_C];
      BR_MI: taken = f[FLAG_N];
      BR_PL: taken = !f[FLAG_N];
      BR_NV: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_writeback_flag_unit.sv
// Architectural status-flags register, flag_op decode and registered
// branch-condition evaluator. Branch queries see the flag value being
// written in the same cycle.
module flag_unit
  import alu_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  input  flag_op_e   flag_op,
  input  logic [2:0] in_flags,
  input  logic       br_req,
  input  br_cond_e   br_cond,
  output logic [2:0] flags,
  output logic       br_taken,
  output logic       br_done
);

  logic [2:0] flags_next;

  // Next-state flags: only an accepted ALU result may change them.
  always_comb begin
    // NOTE: default first so every path assigns flags_next; no latch.
    flags_next = flags;
    if (upd) begin
      unique case (flag_op)
        FOP_HOLD: ;
        FOP_LOAD: flags_next = in_flags;
        FOP_SETC: flags_next[FLAG_C] = 1'b1;
        FOP_CLRC: flags_next[FLAG_C] = 1'b0;
      endcase
    end
  end

  // Flags register and branch result; br_taken holds until the next query.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      flags    <= 3'b000;
      br_taken <= 1'b0;
      br_done  <= 1'b0;
    end else begin
      flags   <= flags_next;
      br_done <= br_req;
      if (br_req) br_taken <= br_eval(br_cond, flags_next);
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry holding register in front of the
// register-file write port, with forwarding of the pending write and the
// status-flags / branch unit.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int RA_W = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [2:0]      in_flags,
  input  logic [RA_W-1:0] in_waddr,
  input  logic            in_rf_we,
  input  logic [1:0]      in_flag_op,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  input  logic            rf_ready,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_addr,
  output logic [DW-1:0]   fwd_data,
  output logic            cin,
  output logic [2:0]      flags,
  input  logic            br_req,
  input  logic [2:0]      br_cond,
  output logic            br_taken,
  output logic            br_done
);

  logic            occ;
  logic            hold_we;
  logic [RA_W-1:0] hold_addr;
  logic [DW-1:0]   hold_data;
  logic            accept;
  logic            wr_done;

  // The slot is free when empty, when its entry needs no write, or when
  // the write drains this cycle (so a new entry can replace it).
  assign in_ready = !occ || !hold_we || rf_ready;
  assign accept   = in_valid && in_ready;

  assign rf_we    = occ && hold_we;
  assign rf_waddr = hold_addr;
  assign rf_wdata = hold_data;
  assign wr_done  = rf_we && rf_ready;

  assign fwd_valid = rf_we;
  assign fwd_addr  = hold_addr;
  assign fwd_data  = hold_data;

  assign cin = flags[FLAG_C];

  // Holding register: capture on accept, retire on write or after one
  // cycle for entries that carry no register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: address/data are reset too so the write port reads zero after reset.
      occ       <= 1'b0;
      hold_we   <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (accept) begin
      occ       <= 1'b1;
      hold_we   <= in_rf_we;
      hold_addr <= in_waddr;
      hold_data <= in_data;
    end else if (occ && (!hold_we || wr_done)) begin
      occ <= 1'b0;
    end
  end

  flag_unit u_flag_unit (
    .clk      (clk),
    .reset    (reset),
    .upd      (accept),
    .flag_op  (flag_op_e'(in_flag_op)),
    .in_flags (in_flags),
    .br_req   (br_req),
    .br_cond  (br_cond_e'(br_cond)),
    .flags    (flags),
    .br_taken (br_taken),
    .br_done  (br_done)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, reset
// corner case, then randomized traffic against a behavioural model.
module tb_alu_writeback;

  localparam int RA_W = 4;
  localparam int DW   = 8;
  localparam int NV   = 18;
  localparam int NRND = 3000;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_flags;
  logic [RA_W-1:0] in_waddr;
  logic            in_rf_we;
  logic [1:0]      in_flag_op;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            rf_ready;
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_addr;
  logic [DW-1:0]   fwd_data;
  logic            cin;
  logic [2:0]      flags;
  logic            br_req;
  logic [2:0]      br_cond;
  logic            br_taken;
  logic            br_done;

  always #5 clk = ~clk;

  alu_writeback #(.RA_W(RA_W), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flags   (in_flags),
    .in_waddr   (in_waddr),
    .in_rf_we   (in_rf_we),
    .in_flag_op (in_flag_op),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_ready   (rf_ready),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .cin        (cin),
    .flags      (flags),
    .br_req     (br_req),
    .br_cond    (br_cond),
    .br_taken   (br_taken),
    .br_done    (br_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic            v;
    logic [DW-1:0]   d;
    logic [2:0]      f;
    logic [RA_W-1:0] a;
    logic            we;
    logic [1:0]      op;
    logic            rdy;
    logic            br;
    logic [2:0]      bc;
    logic            x_ready;
    logic            x_we;
    logic [RA_W-1:0] x_addr;
    logic [DW-1:0]   x_data;
    logic [2:0]      x_flags;
    logic            x_done;
    logic            x_taken;
  } vec_t;

  vec_t vecs [NV];

  task automatic drive(input vec_t t);
    in_valid   = t.v;
    in_data    = t.d;
    in_flags   = t.f;
    in_waddr   = t.a;
    in_rf_we   = t.we;
    in_flag_op = t.op;
    rf_ready   = t.rdy;
    br_req     = t.br;
    br_cond    = t.bc;
  endtask

  // Branch condition truth table written directly from the condition codes.
  function automatic bit cond_true(input bit [2:0] c, input bit [2:0] f);
    bit cy, n, z;
    cy = f[2];
    n  = f[1];
    z  = f[0];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return cy;
      3'd4:    return !cy;
      3'd5:    return n;
      3'd6:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model state
  bit            m_occ, m_we, m_taken, m_done, m_ready, acc, r_rst;
  bit [RA_W-1:0] m_addr;
  bit [DW-1:0]   m_data;
  bit [2:0]      m_flags, nf;

  initial begin
    //            v     d      f       a     we    op     rdy   br    bc        rdy   we    addr  data   flags   done  taken
    vecs[0]  = '{1'b1, 8'h3C, 3'b100, 4'd5, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0,    1'b1, 1'b1, 4'd5, 8'h3C, 3'b100, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 3'b000, 4'd2, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0,    1'b1, 1'b1, 4'd2, 8'hA5, 3'b100, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h11, 3'b010, 4'd7, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0,    1'b0, 1'b1, 4'd2, 8'hA5, 3'b100, 1'b0, 1'b0};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1'b1, 8'h11, 3'b010, 4'd7, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0,    1'b1, 1'b1, 4'd7, 8'h11, 3'b010, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h00, 3'b000, 4'd0, 1'b0, 2'b10, 1'b1, 1'b0, 3'd0,    1'b1, 1'b0, 4'd0, 8'h00, 3'b110, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 3'b000, 4'd0, 1'b0, 2'b11, 1'b1, 1'b0, 3'd0,    1'b1, 1'b0, 4'd0, 8'h00, 3'b010, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0,    1'b1, 1'b0, 4'd0, 8'h00, 3'b010, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h00, 3'b001, 4'd0, 1'b0, 2'b01, 1'b1, 1'b1, 3'd1,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd2,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd3,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd4,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd5,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd6,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd0,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd7,    1'b1, 1'b0, 4'd0, 8'h00, 3'b001, 1'b1, 1'b0};

    // Reset held for two cycles
    reset = 1'b1;
    drive('{1'b0, 8'h00, 3'b000, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0,
            1'b0, 1'b0, 4'd0, 8'h00, 3'b000, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst rf_we", rf_we, 1'b0);
    check("rst fwd_valid", fwd_valid, 1'b0);
    check("rst flags", flags, 3'b000);
    check("rst cin", cin, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst br_done", br_done, 1'b0);
    check("rst br_taken", br_taken, 1'b0);
    check("rst rf_waddr", rf_waddr, 4'd0);
    check("rst rf_wdata", rf_wdata, 8'h00);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d in_ready", i), in_ready, vecs[i].x_ready);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rf_we", i), rf_we, vecs[i].x_we);
      check($sformatf("v%0d fwd_valid", i), fwd_valid, vecs[i].x_we);
      if (vecs[i].x_we) begin
        check($sformatf("v%0d rf_waddr", i), rf_waddr, vecs[i].x_addr);
        check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].x_data);
        check($sformatf("v%0d fwd_addr", i), fwd_addr, vecs[i].x_addr);
        check($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].x_data);
      end
      check($sformatf("v%0d flags", i), flags, vecs[i].x_flags);
      check($sformatf("v%0d cin", i), cin, vecs[i].x_flags[2]);
      check($sformatf("v%0d br_done", i), br_done, vecs[i].x_done);
      check($sformatf("v%0d br_taken", i), br_taken, vecs[i].x_taken);
    end

    // Reset while an entry is held and the register file is stalled
    drive('{1'b1, 8'hA5, 3'b111, 4'd2, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0,
            1'b0, 1'b0, 4'd0, 8'h00, 3'b000, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("midrst pre fwd_valid", fwd_valid, 1'b1);
    check("midrst pre flags", flags, 3'b111);
    check("midrst pre in_ready", in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst rf_we", rf_we, 1'b0);
    check("midrst fwd_valid", fwd_valid, 1'b0);
    check("midrst flags", flags, 3'b000);
    check("midrst cin", cin, 1'b0);
    check("midrst in_ready", in_ready, 1'b1);

    // Randomized traffic against the behavioural model
    m_occ = 0; m_we = 0; m_addr = '0; m_data = '0;
    m_flags = 3'b000; m_taken = 0; m_done = 0;
    for (int cyc = 0; cyc < NRND; cyc++) begin
      r_rst      = ($urandom_range(0, 199) == 0);
      reset      = r_rst;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = DW'($urandom);
      in_flags   = 3'($urandom);
      in_waddr   = RA_W'($urandom);
      in_rf_we   = ($urandom_range(0, 3) != 0);
      in_flag_op = 2'($urandom);
      rf_ready   = ($urandom_range(0, 9) < 7);
      br_req     = ($urandom_range(0, 1) == 1);
      br_cond    = 3'($urandom);
      #1;
      m_ready = !m_occ || !m_we || rf_ready;
      check("rnd in_ready", in_ready, m_ready);

      if (r_rst) begin
        m_occ = 0; m_we = 0; m_addr = '0; m_data = '0;
        m_flags = 3'b000; m_taken = 0; m_done = 0;
      end else begin
        acc = in_valid && m_ready;
        nf  = m_flags;
        if (acc) begin
          case (in_flag_op)
            2'b01:   nf = in_flags;
            2'b10:   nf = {1'b1, m_flags[1:0]};
            2'b11:   nf = {1'b0, m_flags[1:0]};
            default: nf = m_flags;
          endcase
        end
        m_done = br_req;
        if (br_req) m_taken = cond_true(br_cond, nf);
        if (acc) begin
          m_occ  = 1;
          m_we   = in_rf_we;
          m_addr = in_waddr;
          m_data = in_data;
        end else if (m_occ && (!m_we || rf_ready)) begin
          m_occ = 0;
        end
        m_flags = nf;
      end

      @(posedge clk);
      #1;
      check("rnd rf_we", rf_we, m_occ && m_we);
      check("rnd fwd_valid", fwd_valid, m_occ && m_we);
      if (m_occ && m_we) begin
        check("rnd rf_waddr", rf_waddr, m_addr);
        check("rnd rf_wdata", rf_wdata, m_data);
        check("rnd fwd_addr", fwd_addr, m_addr);
        check("rnd fwd_data", fwd_data, m_data);
      end
      check("rnd flags", flags, m_flags);
      check("rnd cin", cin, m_flags[2]);
      check("rnd br_done", br_done, m_done);
      check("rnd br_taken", br_taken, m_taken);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Pipeline stage directly downstream of the combinational ALU.
- Registers the ALU result and {C,N,Z} flags into a one-entry holding register, then drives the register-file write port.
- Owns the architectural status-flags register. Feeds the stored carry back to the ALU `cin` input.
- Evaluates branch conditions against the flags.

Parameters:
- RA_W, 4, register-file address width
- DW, 8, datapath width; matches ALU width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU stage presents a result
- in_ready  out  1  stage can accept this cycle
- in_data  in  DW  ALU `out`
- in_flags  in  3  ALU flags {C,N,Z}
- in_waddr  in  RA_W  destination register
- in_rf_we  in  1  result must be written to register file
- in_flag_op  in  2  00 hold, 01 load ALU flags, 10 set C, 11 clear C
- rf_we  out  1  register-file write request
- rf_waddr  out  RA_W  write address
- rf_wdata  out  DW  write data
- rf_ready  in  1  register file accepts write this cycle (port shared with loads)
- fwd_valid  out  1  held entry has a pending register write
- fwd_addr  out  RA_W  address of the pending write
- fwd_data  out  DW  data of the pending write
- cin  out  1  stored carry flag, to ALU `cin`
- flags  out  3  stored {C,N,Z}
- br_req  in  1  branch-condition query
- br_cond  in  3  condition code (see Behaviour)
- br_taken  out  1  registered result of the query
- br_done  out  1  one-cycle pulse; `br_taken` is valid

Behaviour:
- Reset (synchronous, active-high): occupancy `occ`=0, flags=3'b000, `br_taken`=0, `br_done`=0. Hence `rf_we`=0, `fwd_valid`=0, `cin`=0; `rf_waddr`/`rf_wdata`=0.
- Reset mid-operation: the held entry is discarded without a write; flags are cleared.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = !occ | !hold_we | rf_ready (combinational).
  - hold_we is the stored `in_rf_we`.
- Held entry:
  - Captured on accept; occ=1 next cycle.
  - `rf_we` = occ & hold_we; `rf_waddr`/`rf_wdata` come from the held registers.
  - Write completes when rf_we & rf_ready.
- Retire: occ clears when the write completes, or in the cycle after capture if hold_we=0.
- Simultaneous retire and accept: the new entry replaces the old. Back-to-back throughput is 1/cycle while `rf_ready`=1.
- Latency: a result accepted at cycle t drives `rf_we` at t+1.
- Forwarding: fwd_valid = occ & hold_we. fwd_addr/fwd_data equal the held values. Deasserts the cycle after the write completes.
- Flags update happens on accept only; no accept means flags hold. By `in_flag_op`:
  - 01: flags <= in_flags.
  - 10: C <= 1; N,Z unchanged.
  - 11: C <= 0; N,Z unchanged.
  - 00: hold.
- `cin` and `flags` reflect the new value at the cycle after accept. No same-cycle bypass to the ALU.
- Branch conditions `br_cond`:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 !N
  - 111 never
- Branch evaluation timing:
  - br_req at cycle t gives br_done=1 and br_taken at t+1.
  - Evaluation uses the next-state flags, i.e. it bypasses an update accepted in cycle t.
  - `br_taken` holds its value until the next br_req.
- If rf_ready stays low, the held entry, `fwd_*`, and `in_ready`=0 persist indefinitely. No timeout.

Decomposition:
- Shared package holds:
  - flag index constants FLAG_C=2, FLAG_N=1, FLAG_Z=0;
  - flag_op enum (FOP_HOLD, FOP_LOAD, FOP_SETC, FOP_CLRC);
  - branch condition enum (BR_AL, BR_EQ, BR_NE, BR_CS, BR_CC, BR_MI, BR_PL, BR_NV).
- One sub-module: `flag_unit`, containing the flags register, the flag_op decode, and the branch evaluator.
- Holding register and handshake stay in the top module.

Test Plan:
- Reset held 2 cycles, then released → rf_we=0, fwd_valid=0, flags=000, cin=0, in_ready=1, br_done=0.
- Accept data=0x3C, waddr=5, rf_we=1, flag_op=01, flags=3'b100 with rf_ready=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x3C, cin=1.
- Hold rf_ready=0 for 3 cycles with an entry held (waddr=2, data=0xA5) → in_ready=0 and fwd_valid=1/fwd_addr=2/fwd_data=0xA5 stable. Raise rf_ready → write completes; next entry is accepted in the same cycle.
- Accept flag_op=10 and then flag_op=11 with in_rf_we=0 → cin goes 1, then 0; N,Z unchanged; rf_we never asserted.
- Accept flag_op=01 with flags=001 in the same cycle as br_req with cond=001 → br_done=1 and br_taken=1 next cycle. A query with cond=010 the next cycle → br_taken=0.
- Assert reset while an entry is held with rf_ready=0 → no write occurs; occ=0 and flags=000 on the following cycle.
